// File: rtl/intc_pkg.sv
// Shared types and default sizing for the interrupt arbiter.
package intc_pkg;

    localparam int unsigned INTC_NUM_SRC = 16;
    localparam int unsigned INTC_PRIO_W  = 3;
    localparam int unsigned INTC_ID_W    = 4;

    typedef enum logic [1:0] {
        SENSE_LOW  = 2'b00,
        SENSE_FALL = 2'b01,
        SENSE_RISE = 2'b10,
        SENSE_BOTH = 2'b11
    } sense_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SERV = 2'b10
    } arb_state_e;

endpackage

// File: rtl/intc_prio_tree.sv
// Combinational winner finder: highest priority among eligible sources, lowest index on ties.
module intc_prio_tree
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = INTC_NUM_SRC,
    parameter int unsigned PRIO_W  = INTC_PRIO_W,
    parameter int unsigned ID_W    = INTC_ID_W
) (
    input  logic [NUM_SRC-1:0]        elig_i,
    input  logic [NUM_SRC*PRIO_W-1:0] ipr_i,
    output logic                      valid_o,
    output logic [ID_W-1:0]           id_o,
    output logic [PRIO_W-1:0]         prio_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        prio_o  = '0;
        // Ascending scan with strict compare keeps the lowest index on equal priority.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig_i[i] && (!valid_o || (ipr_i[i*PRIO_W +: PRIO_W] > prio_o))) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
                prio_o  = ipr_i[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: per-source pending latch, eligibility, req/ack/eoi sequencer.
// Define INTC_REQ_CANCEL_EN to withdraw a presented request that is no longer eligible.
module interrupt_arbiter
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = INTC_NUM_SRC,
    parameter int unsigned PRIO_W  = INTC_PRIO_W,
    parameter int unsigned ID_W    = INTC_ID_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        irq_in,
    input  logic [NUM_SRC-1:0]        ier,
    input  logic [2*NUM_SRC-1:0]      iscr,
    input  logic [NUM_SRC*PRIO_W-1:0] ipr,
    input  logic [PRIO_W-1:0]         cpu_mask,
    output logic                      int_req,
    output logic [ID_W-1:0]           int_id,
    output logic [PRIO_W-1:0]         int_prio,
    input  logic                      int_ack,
    input  logic                      int_eoi,
    output logic [NUM_SRC-1:0]        pend_out
);

    arb_state_e          state_q, state_d;
    logic                int_req_q, int_req_d;
    logic [ID_W-1:0]     int_id_q, int_id_d;
    logic [PRIO_W-1:0]   int_prio_q, int_prio_d;
    logic [NUM_SRC-1:0]  irq_d_q;
    logic [NUM_SRC-1:0]  pend_q, pend_d;
    logic [NUM_SRC-1:0]  elig;
    logic                ack_clr;
    logic                win_valid;
    logic [ID_W-1:0]     win_id;
    logic [PRIO_W-1:0]   win_prio;
    sense_e              sense;
    logic                edge_set;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pend_q[i] & ier[i] & (ipr[i*PRIO_W +: PRIO_W] > cpu_mask);
        end
    end

    intc_prio_tree #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_prio_tree (
        .elig_i  (elig),
        .ipr_i   (ipr),
        .valid_o (win_valid),
        .id_o    (win_id),
        .prio_o  (win_prio)
    );

    // Level sources track the line directly; edge sources latch until acked, and a
    // fresh edge in the ack cycle wins over the clear.
    always_comb begin
        pend_d   = pend_q;
        sense    = SENSE_LOW;
        edge_set = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sense    = sense_e'(iscr[2*i +: 2]);
            edge_set = 1'b0;
            unique case (sense)
                SENSE_FALL: edge_set = irq_d_q[i] & ~irq_in[i];
                SENSE_RISE: edge_set = ~irq_d_q[i] & irq_in[i];
                SENSE_BOTH: edge_set = irq_d_q[i] ^ irq_in[i];
                default:    edge_set = 1'b0;
            endcase
            if (sense == SENSE_LOW) begin
                pend_d[i] = ~irq_in[i];
            end else begin
                pend_d[i] = edge_set | (pend_q[i] & ~(ack_clr && (int_id_q == ID_W'(i))));
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        int_req_d  = int_req_q;
        int_id_d   = int_id_q;
        int_prio_d = int_prio_q;
        ack_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    int_id_d   = win_id;
                    int_prio_d = win_prio;
                    int_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    ack_clr   = 1'b1;
                    int_req_d = 1'b0;
                    state_d   = SERV;
                end
`ifdef INTC_REQ_CANCEL_EN
                else if (!elig[int_id_q]) begin
                    int_req_d = 1'b0;
                    state_d   = IDLE;
                end
`endif
            end
            SERV: begin
                if (int_eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                int_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            int_req_q  <= 1'b0;
            int_id_q   <= '0;
            int_prio_q <= '0;
            irq_d_q    <= '1;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            int_req_q  <= int_req_d;
            int_id_q   <= int_id_d;
            int_prio_q <= int_prio_d;
            irq_d_q    <= irq_in;
            pend_q     <= pend_d;
        end
    end

    assign int_req  = int_req_q;
    assign int_id   = int_id_q;
    assign int_prio = int_prio_q;
    assign pend_out = pend_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter (default build, request cancel disabled).
module tb_interrupt_arbiter;

    localparam int unsigned NUM_SRC = 16;
    localparam int unsigned PRIO_W  = 3;
    localparam int unsigned ID_W    = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        irq_in;
    logic [NUM_SRC-1:0]        ier;
    logic [2*NUM_SRC-1:0]      iscr;
    logic [NUM_SRC*PRIO_W-1:0] ipr;
    logic [PRIO_W-1:0]         cpu_mask;
    logic                      int_req;
    logic [ID_W-1:0]           int_id;
    logic [PRIO_W-1:0]         int_prio;
    logic                      int_ack;
    logic                      int_eoi;
    logic [NUM_SRC-1:0]        pend_out;

    int total;
    int bad;

    interrupt_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .ier      (ier),
        .iscr     (iscr),
        .ipr      (ipr),
        .cpu_mask (cpu_mask),
        .int_req  (int_req),
        .int_id   (int_id),
        .int_prio (int_prio),
        .int_ack  (int_ack),
        .int_eoi  (int_eoi),
        .pend_out (pend_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lines idle high, every source falling-edge sensed, disabled, priority 0.
    task automatic do_reset();
        rst_n    = 1'b0;
        irq_in   = '1;
        ier      = '0;
        iscr     = {NUM_SRC{2'b01}};
        ipr      = '0;
        cpu_mask = '0;
        int_ack  = 1'b0;
        int_eoi  = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        irq_in   = '1;
        ier      = '0;
        iscr     = {NUM_SRC{2'b01}};
        ipr      = '0;
        cpu_mask = '0;
        int_ack  = 1'b0;
        int_eoi  = 1'b0;
        #2;
        total++;
        if (int_req !== 1'b0 || int_id !== 4'd0 || int_prio !== 3'd0 || pend_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: req=%b id=%0d prio=%0d pend=%h, want 0/0/0/0000",
                     int_req, int_id, int_prio, pend_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (int_req !== 1'b0 || pend_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_release: req=%b pend=%h, want 0/0000", int_req, pend_out);
        end
    endtask

    task automatic test_falling_edge();
        do_reset();
        ier[3]       = 1'b1;
        ipr[9 +: 3]  = 3'd5;
        tick();
        irq_in[3] = 1'b0;
        tick();
        total++;
        if (pend_out[3] !== 1'b1 || int_req !== 1'b0) begin
            bad++;
            $display("FAIL fall_pend: pend3=%b req=%b, want 1/0", pend_out[3], int_req);
        end
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd3 || int_prio !== 3'd5) begin
            bad++;
            $display("FAIL fall_req: req=%b id=%0d prio=%0d, want 1/3/5", int_req, int_id, int_prio);
        end
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd3) begin
            bad++;
            $display("FAIL fall_hold: req=%b id=%0d, want 1/3", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        total++;
        if (int_req !== 1'b0 || pend_out[3] !== 1'b0) begin
            bad++;
            $display("FAIL fall_ack: req=%b pend3=%b, want 0/0", int_req, pend_out[3]);
        end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b0 || pend_out !== 16'h0) begin
            bad++;
            $display("FAIL fall_eoi: req=%b pend=%h, want 0/0000", int_req, pend_out);
        end
    endtask

    task automatic test_tie_break();
        do_reset();
        ier[2] = 1'b1;
        ier[7] = 1'b1;
        ipr[6 +: 3]  = 3'd4;
        ipr[21 +: 3] = 3'd6;
        irq_in[2] = 1'b0;
        irq_in[7] = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd7 || int_prio !== 3'd6) begin
            bad++;
            $display("FAIL tie_prio: req=%b id=%0d prio=%0d, want 1/7/6", int_req, int_id, int_prio);
        end
        do_reset();
        ier[2] = 1'b1;
        ier[7] = 1'b1;
        ipr[6 +: 3]  = 3'd4;
        ipr[21 +: 3] = 3'd4;
        irq_in[2] = 1'b0;
        irq_in[7] = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd2 || int_prio !== 3'd4) begin
            bad++;
            $display("FAIL tie_index: req=%b id=%0d prio=%0d, want 1/2/4", int_req, int_id, int_prio);
        end
    endtask

    task automatic test_req_hold();
        do_reset();
        ier[4] = 1'b1;
        ier[9] = 1'b1;
        ipr[12 +: 3] = 3'd2;
        ipr[27 +: 3] = 3'd7;
        irq_in[4] = 1'b0;
        tick();
        tick();
        irq_in[9] = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd4 || int_prio !== 3'd2 || pend_out[9] !== 1'b1) begin
            bad++;
            $display("FAIL hold_higher: req=%b id=%0d prio=%0d pend9=%b, want 1/4/2/1",
                     int_req, int_id, int_prio, pend_out[9]);
        end
        cpu_mask = 3'd5;
        tick();
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd4) begin
            bad++;
            $display("FAIL hold_mask: req=%b id=%0d, want 1/4", int_req, int_id);
        end
    endtask

    task automatic test_mask();
        do_reset();
        ier[1] = 1'b1;
        ipr[3 +: 3] = 3'd3;
        cpu_mask = 3'd3;
        irq_in[1] = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (int_req !== 1'b0 || pend_out[1] !== 1'b1) begin
            bad++;
            $display("FAIL mask_block: req=%b pend1=%b, want 0/1", int_req, pend_out[1]);
        end
        cpu_mask = 3'd2;
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd1 || int_prio !== 3'd3) begin
            bad++;
            $display("FAIL mask_open: req=%b id=%0d prio=%0d, want 1/1/3", int_req, int_id, int_prio);
        end
    endtask

    task automatic test_level();
        do_reset();
        iscr[1:0] = 2'b00;
        ier[0] = 1'b1;
        ipr[0 +: 3] = 3'd2;
        irq_in[0] = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd0 || int_prio !== 3'd2) begin
            bad++;
            $display("FAIL level_req: req=%b id=%0d prio=%0d, want 1/0/2", int_req, int_id, int_prio);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        total++;
        if (int_req !== 1'b0 || pend_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL level_ack: req=%b pend0=%b, want 0/1", int_req, pend_out[0]);
        end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd0) begin
            bad++;
            $display("FAIL level_rereq: req=%b id=%0d, want 1/0", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq_in[0] = 1'b1;
        tick();
        total++;
        if (pend_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL level_release: pend0=%b, want 0", pend_out[0]);
        end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b0) begin
            bad++;
            $display("FAIL level_quiet: req=%b, want 0", int_req);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        ier[5] = 1'b1;
        ipr[15 +: 3] = 3'd6;
        irq_in[5] = 1'b0;
        tick();
        irq_in[5] = 1'b1;
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd5) begin
            bad++;
            $display("FAIL setclr_req: req=%b id=%0d, want 1/5", int_req, int_id);
        end
        irq_in[5] = 1'b0;
        int_ack   = 1'b1;
        tick();
        int_ack = 1'b0;
        total++;
        if (int_req !== 1'b0 || pend_out[5] !== 1'b1) begin
            bad++;
            $display("FAIL setclr_pend: req=%b pend5=%b, want 0/1", int_req, pend_out[5]);
        end
        tick();
        tick();
        total++;
        if (int_req !== 1'b0) begin
            bad++;
            $display("FAIL setclr_nonest: req=%b, want 0", int_req);
        end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        tick();
        total++;
        if (int_req !== 1'b1 || int_id !== 4'd5 || int_prio !== 3'd6) begin
            bad++;
            $display("FAIL setclr_repres: req=%b id=%0d prio=%0d, want 1/5/6",
                     int_req, int_id, int_prio);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        ier[3] = 1'b1;
        ipr[9 +: 3] = 3'd5;
        irq_in[3] = 1'b0;
        tick();
        tick();
        total++;
        if (int_req !== 1'b1) begin
            bad++;
            $display("FAIL midreq_setup: req=%b, want 1", int_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (int_req !== 1'b0 || pend_out !== 16'h0 || int_id !== 4'd0) begin
            bad++;
            $display("FAIL midreq_async: req=%b pend=%h id=%0d, want 0/0000/0",
                     int_req, pend_out, int_id);
        end
        irq_in = '1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (int_req !== 1'b0 || pend_out !== 16'h0) begin
            bad++;
            $display("FAIL midreq_after: req=%b pend=%h, want 0/0000", int_req, pend_out);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_falling_edge();
        test_tie_break();
        test_req_hold();
        test_mask();
        test_level();
        test_set_clear();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
- Interrupt arbiter and sequencer that sits behind the interrupt register bank.
- Consumes the IER, ISCRH/ISCRL and IPR register contents plus the raw interrupt lines.
- Latches pending requests per source and selects the highest-priority eligible source.
- Presents the winner to the CPU with a req/ack handshake, then holds it in service until end-of-interrupt.

Parameters:
- NUM_SRC, 16, number of interrupt sources
- PRIO_W, 3, width of the per-source priority field (matches the IPR 3-bit fields)
- ID_W, 4, width of the source index; must equal clog2(NUM_SRC)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_in  in  NUM_SRC  raw interrupt lines, already synchronised to clk
- ier  in  NUM_SRC  per-source enable; bit i comes from IER bit i
- iscr  in  2*NUM_SRC  per-source sense: 00 low level, 01 falling edge, 10 rising edge, 11 both edges; the {ISCRH,ISCRL} pair
- ipr  in  NUM_SRC*PRIO_W  per-source priority; source i uses bits [i*PRIO_W +: PRIO_W]
- cpu_mask  in  PRIO_W  current CPU mask level
- int_req  out  1  interrupt request to the CPU
- int_id  out  ID_W  winning source index
- int_prio  out  PRIO_W  winning source priority
- int_ack  in  1  CPU accepts the presented request
- int_eoi  in  1  CPU finishes the in-service interrupt
- pend_out  out  NUM_SRC  pending flags, for status readback

Behaviour:
- Reset state: all registers clear. int_req=0, int_id=0, int_prio=0, pend_out=0, FSM=IDLE. irq_d resets to all ones, so an idle-high line causes no edge at reset release.
- Edge detection: irq_d is registered from irq_in every cycle.
  - Falling edge: irq_d=1 and irq_in=0.
  - Rising edge: irq_d=0 and irq_in=1.
  - Detected edges set pend[i] on the same clock edge at which they are sampled.
- Level mode (iscr=00): pend[i] is registered as !irq_in[i] every cycle. Acknowledge has no effect; the source must release its line.
- Pending latch is independent of ier.
- Eligibility: elig[i] = pend[i] & ier[i] & (prio[i] > cpu_mask). Priority 0 is therefore never eligible.
- Winner selection: maximum priority among eligible sources; on equal priority the lowest index wins.
- FSM states:
  - IDLE: if any source is eligible, register int_id/int_prio from the winner, set int_req=1, go to REQ. The earliest int_req is 2 clocks after the edge is sampled.
  - REQ: int_id/int_prio are held stable and int_req stays 1 until int_ack is sampled high. On ack: clear pend[int_id] (edge modes only), set int_req=0, go to SERV.
  - SERV: wait for int_eoi, then go to IDLE. No new request is issued while in SERV (no nesting).
- int_ack outside REQ and int_eoi outside SERV are ignored.
- A new edge on the same cycle as the ack-clear of the same source: the set wins, so the source stays pending.
- Winner changes while in REQ (a higher source arrives, or cpu_mask rises) do not alter int_id; re-arbitration happens only in IDLE.
- Asserting rst_n low mid-handshake drops int_req asynchronously and clears all state.

Optional Feature:
- Macro INTC_REQ_CANCEL_EN.
- When defined: in REQ, if the presented source is no longer eligible (ier cleared, level released, or prio <= cpu_mask), drop int_req the next cycle and return to IDLE without clearing pend.
- When undefined: the request is held until int_ack regardless of eligibility.

Decomposition:
- Package intc_pkg holds:
  - the sense_e enum (SENSE_LOW, SENSE_FALL, SENSE_RISE, SENSE_BOTH)
  - the arb_state_e enum (IDLE, REQ, SERV)
  - NUM_SRC, PRIO_W and ID_W defaults
- Sub-module intc_prio_tree: combinational max-priority and lowest-index finder over elig and ipr, producing a valid flag, id and prio. The FSM and pending logic stay in the top module.

Test Plan:
- Falling edge: src 3, iscr=01, ier[3]=1, prio 5, cpu_mask 0. Drive irq_in[3] 1->0 -> int_req=1, int_id=3, int_prio=5 two clocks later. Ack -> pend_out[3]=0. eoi -> IDLE.
- Priority tie-break: srcs 2 and 7 pending together. prio 4/6 -> id=7. prio 4/4 -> id=2.
- Mask: prio 3, cpu_mask 3 -> no int_req. Drop cpu_mask to 2 -> int_req next cycle with id of that source.
- Level mode: src 0, iscr=00, held low through ack/eoi -> re-requested after eoi. Released high -> pend_out[0]=0, no further request.
- Simultaneous set/clear: second falling edge on src 5 in the same cycle as its ack -> pend_out[5] stays 1 and is re-presented after eoi.
- Reset mid-REQ: rst_n low while int_req=1 -> int_req=0 immediately. After release: no request, and no spurious edge from idle-high lines.
